// File: rtl/ball_seek_ctrl.sv
// Drive-direction FSM: steers toward the ball from the mic-side signal, backs off the
// boundary wire, honours pause, and stops on ball capture or search timeout.
module ball_seek_ctrl #(
    parameter int                DUTY_W         = 2,
    parameter logic [DUTY_W-1:0] DUTY_FAST      = 2'b10,
    parameter logic [DUTY_W-1:0] DUTY_SLOW      = 2'b00,
    parameter logic [DUTY_W-1:0] DUTY_BACK      = 2'b11,
    parameter int                BACKUP_CYCLES  = 100_000_000,
    parameter int                SETTLE_CYCLES  = 1_000_000,
    parameter int                SEARCH_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Enable,
    input  logic              BallSignal,
    input  logic              Pause,
    input  logic              Inductance,
    input  logic              Ball_Detect,
    output logic              FWD_A,
    output logic              FWD_B,
    output logic              BWD_A,
    output logic              BWD_B,
    output logic [DUTY_W-1:0] Duty_SelA,
    output logic [DUTY_W-1:0] Duty_SelB,
    output logic              Done,
    output logic              Timeout,
    output logic [2:0]        State
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_TURN_RIGHT = 3'd1,
        S_TURN_LEFT  = 3'd2,
        S_PAUSE      = 3'd3,
        S_BACKUP     = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;
    localparam int BK_W  = $clog2(BACKUP_CYCLES) + 1;
    localparam int TO_W  = $clog2(SEARCH_TIMEOUT) + 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [BK_W-1:0]  BK_LAST  = BK_W'(BACKUP_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((SEARCH_TIMEOUT > 0) ? SEARCH_TIMEOUT - 1 : 0);
    localparam bit               TO_EN    = (SEARCH_TIMEOUT != 0);

    // Two return registers: a pause taken during BACKUP must still let BACKUP
    // return to the turn that preceded it.
    state_t state_q, state_d;
    state_t resume_q, resume_d;
    state_t turn_ret_q, turn_ret_d;
    logic   enable_q;
    logic   timeout_q, timeout_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [BK_W-1:0]  bk_q, bk_d;
    logic [TO_W-1:0]  to_q, to_d;

    logic             start;
    logic             disagree;
    logic             to_hit;
    logic [TO_W-1:0]  to_inc;
    logic [BK_W-1:0]  bk_sat_inc;
    state_t           turn_dir;
    state_t           other_turn;

    always_comb begin
        start      = Enable & ~enable_q;
        turn_dir   = BallSignal ? S_TURN_RIGHT : S_TURN_LEFT;
        other_turn = (state_q == S_TURN_RIGHT) ? S_TURN_LEFT : S_TURN_RIGHT;
        disagree   = BallSignal != (state_q == S_TURN_RIGHT);
        to_hit     = TO_EN && (to_q >= TO_LAST);
        to_inc     = (to_q >= TO_LAST) ? to_q : to_q + TO_W'(1);
        bk_sat_inc = (bk_q >= BK_LAST) ? bk_q : bk_q + BK_W'(1);

        state_d    = state_q;
        resume_d   = resume_q;
        turn_ret_d = turn_ret_q;
        timeout_d  = timeout_q;
        settle_d   = settle_q;
        bk_d       = bk_q;
        to_d       = to_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = turn_dir;
                    timeout_d = 1'b0;
                    settle_d  = '0;
                    bk_d      = '0;
                    to_d      = '0;
                end
            end
            S_TURN_RIGHT, S_TURN_LEFT: begin
                to_d     = to_inc;
                settle_d = '0;
                if (Ball_Detect) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b0;
                end else if (Pause) begin
                    state_d  = S_PAUSE;
                    resume_d = state_q;
                end else if (Inductance) begin
                    state_d    = S_BACKUP;
                    turn_ret_d = state_q;
                    bk_d       = '0;
                end else if (to_hit) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else if (disagree) begin
                    if (settle_q >= SET_LAST) begin
                        state_d = other_turn;
                    end else begin
                        settle_d = settle_q + SET_W'(1);
                    end
                end
            end
            S_PAUSE: begin
                if (Ball_Detect) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b0;
                end else if (!Pause) begin
                    state_d = resume_q;
                    if (resume_q != S_BACKUP) begin
                        settle_d = '0;
                    end
                end
            end
            S_BACKUP: begin
                to_d = to_inc;
                if (Ball_Detect) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b0;
                end else if (Pause) begin
                    // The cycle just spent reversing counts; saturate so a pause
                    // at terminal count re-decides on resume instead of wrapping.
                    state_d  = S_PAUSE;
                    resume_d = S_BACKUP;
                    bk_d     = bk_sat_inc;
                end else if (to_hit) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else if (bk_q >= BK_LAST) begin
                    bk_d = '0;
                    if (!Inductance) begin
                        state_d = turn_ret_q;
                    end
                end else begin
                    bk_d = bk_q + BK_W'(1);
                end
            end
            default: begin
                state_d    = S_IDLE;
                resume_d   = S_IDLE;
                turn_ret_d = S_IDLE;
                timeout_d  = 1'b0;
                settle_d   = '0;
                bk_d       = '0;
                to_d       = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            resume_q   <= S_IDLE;
            turn_ret_q <= S_IDLE;
            enable_q   <= 1'b0;
            timeout_q  <= 1'b0;
            settle_q   <= '0;
            bk_q       <= '0;
            to_q       <= '0;
            FWD_A      <= 1'b0;
            FWD_B      <= 1'b0;
            BWD_A      <= 1'b0;
            BWD_B      <= 1'b0;
            Duty_SelA  <= '0;
            Duty_SelB  <= '0;
            Done       <= 1'b0;
            Timeout    <= 1'b0;
        end else begin
            state_q    <= state_d;
            resume_q   <= resume_d;
            turn_ret_q <= turn_ret_d;
            enable_q   <= Enable;
            timeout_q  <= timeout_d;
            settle_q   <= settle_d;
            bk_q       <= bk_d;
            to_q       <= to_d;

            // Moore outputs decoded from the next state so they align with State.
            FWD_A     <= 1'b0;
            FWD_B     <= 1'b0;
            BWD_A     <= 1'b0;
            BWD_B     <= 1'b0;
            Duty_SelA <= '0;
            Duty_SelB <= '0;
            Done      <= 1'b0;
            Timeout   <= 1'b0;
            case (state_d)
                S_TURN_RIGHT: begin
                    FWD_A     <= 1'b1;
                    FWD_B     <= 1'b1;
                    Duty_SelA <= DUTY_FAST;
                    Duty_SelB <= DUTY_SLOW;
                end
                S_TURN_LEFT: begin
                    FWD_A     <= 1'b1;
                    FWD_B     <= 1'b1;
                    Duty_SelA <= DUTY_SLOW;
                    Duty_SelB <= DUTY_FAST;
                end
                S_BACKUP: begin
                    BWD_A     <= 1'b1;
                    BWD_B     <= 1'b1;
                    Duty_SelA <= DUTY_BACK;
                    Duty_SelB <= DUTY_BACK;
                end
                S_DONE: begin
                    Done    <= 1'b1;
                    Timeout <= timeout_d;
                end
                default: ;
            endcase
        end
    end

    assign State = state_q;

endmodule

// File: doc/ball_seek_ctrl.md
Name: ball_seek_ctrl

Overview:
Parametrised drive-direction FSM that steers the robot toward the ball using the mic-side signal, then stops when the ball is detected. Sits between the ball-sense logic and the dual PWM / motor driver, like the existing direction controllers. Over the previous generation it adds:
- configurable duty width and levels
- hysteresis on the steering input
- a parametrised inductance back-up that re-arms while the boundary is still sensed
- a search timeout
- a clean synchronous reset

Parameters:
DUTY_W, 2, width of each Duty_Sel output
DUTY_FAST, 2'b10, duty code for the outer wheel when turning
DUTY_SLOW, 2'b00, duty code for the inner wheel when turning
DUTY_BACK, 2'b11, duty code for both wheels in BACKUP
BACKUP_CYCLES, 100_000_000, cycles of reverse drive per inductance event (minimum 1)
SETTLE_CYCLES, 1_000_000, consecutive cycles BallSignal must disagree before the turn direction flips (minimum 1)
SEARCH_TIMEOUT, 0, search-cycle limit before abort; 0 disables the timeout

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
Enable  in  1  search start; acts on its rising edge
BallSignal  in  1  1 = right mic closer, 0 = left mic closer
Pause  in  1  level; holds motors off while high
Inductance  in  1  level; boundary wire sensed
Ball_Detect  in  1  level; ball captured
FWD_A, FWD_B, BWD_A, BWD_B  out  1 each  motor direction enables (A = left, B = right)
Duty_SelA, Duty_SelB  out  DUTY_W each  duty codes to PWM
Done  out  1  search finished (ball found or timed out)
Timeout  out  1  search ended by timeout
State  out  3  encoded state, for debug

Behaviour:
- Interface is fixed: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: on rst=1 at posedge, the following clear to 0:
  - State = IDLE
  - all direction outputs, both Duty_Sel, Done, Timeout
  - all counters, and the Enable edge register
- Start event: start = Enable & ~Enable_q, where Enable_q is Enable registered on posedge clk.
- State encoding: IDLE=0, TURN_RIGHT=1, TURN_LEFT=2, PAUSE=3, BACKUP=4, DONE=5.
- Outputs are registered Moore outputs, valid the cycle the FSM enters a state (1-cycle latency from the input that caused the transition).
- Transition priority per cycle, in active states (TURN_*, PAUSE, BACKUP): Ball_Detect > Pause > Inductance > timeout > steering.
- IDLE:
  - start -> TURN_RIGHT if BallSignal=1, else TURN_LEFT.
  - Ball_Detect is ignored in IDLE.
- TURN_RIGHT:
  - FWD_A=FWD_B=1, BWD=0; Duty_SelA=DUTY_FAST, Duty_SelB=DUTY_SLOW.
- TURN_LEFT:
  - Same directions, duty codes mirrored.
- Hysteresis:
  - settle_cnt increments each cycle BallSignal disagrees with the current turn.
  - It clears on agreement, or on entering any turn state.
  - When settle_cnt reaches SETTLE_CYCLES-1 while disagreeing, the FSM switches to the other turn state the next cycle.
- Ball_Detect=1 in an active state -> DONE, with Done=1 and Timeout=0.
- Pause=1 in TURN_* or BACKUP -> PAUSE, and that state is recorded in prev_state.
- PAUSE:
  - All motor outputs are 0 and all counters are frozen.
  - Pause=0 -> prev_state, with the BACKUP count preserved.
- Inductance=1 in TURN_* -> BACKUP; prev_state is set to the turn state and bk_cnt clears.
- BACKUP:
  - BWD_A=BWD_B=1, FWD=0, both Duty_Sel=DUTY_BACK.
  - bk_cnt counts 0..BACKUP_CYCLES-1.
  - At terminal count with Inductance=1: bk_cnt reloads to 0 and the FSM stays in BACKUP.
  - At terminal count with Inductance=0: return to prev_state.
  - Inductance changes mid-count have no effect until terminal count.
- Search timer:
  - to_cnt counts in TURN_* and BACKUP, is frozen in PAUSE, and clears on start.
  - If SEARCH_TIMEOUT≠0 and to_cnt reaches SEARCH_TIMEOUT-1 -> DONE, with Done=1 and Timeout=1.
- DONE:
  - Motors are off.
  - Done and Timeout hold until a start event or rst.
  - start clears both flags and enters a turn state per BallSignal, as from IDLE.
- Simultaneous start and Ball_Detect in IDLE or DONE: start wins.
- Counter widths are $clog2 of their limit plus 1; counters never wrap within a state.
- Illegal State encodings go to IDLE next cycle with outputs cleared.

Test Plan:
Parameters for all scenarios: BACKUP_CYCLES=8, SETTLE_CYCLES=4, SEARCH_TIMEOUT=50.
1. rst high 2 cycles, then Enable 0->1 with BallSignal=1 -> one cycle after the edge: State=1, FWD_A=FWD_B=1, Duty_SelA=2'b10, Duty_SelB=2'b00, Done=0.
2. In TURN_RIGHT, BallSignal=0 for 3 cycles then 1, then 0 for 4 cycles -> no flip after the 3-cycle glitch; State=2 (duty mirrored) one cycle after the 4th consecutive 0.
3. In TURN_LEFT, Inductance pulse 1 cycle -> BWD_A=BWD_B=1, duties 2'b11 for exactly 8 cycles, then State=2. Repeat with Inductance held 12 cycles -> 16 cycles of BACKUP, then TURN_LEFT.
4. Pause=1 at backup cycle 3 for 10 cycles -> all motor outputs 0, State=3; on release, 5 more BACKUP cycles, then the prior turn state; the timeout count excludes the 10 paused cycles.
5. No Ball_Detect after start -> at search cycle 50: State=5, Done=1, Timeout=1, motors 0. A new Enable edge clears both flags and restarts.
6. Ball_Detect=1 during BACKUP -> next cycle State=5, Done=1, Timeout=0. rst mid-TURN -> next cycle all outputs 0, State=0.
